// File: rtl/kip_kernel_arbiter.sv
// Packet-granular round-robin merge of NUM_KERNELS kernel AXIS control streams
// into one registered AXIS stream (2-entry skid buffer) for the KIP router.
module kip_kernel_arbiter #(
   parameter int NUM_KERNELS          = 4,
   parameter int AXIS_DATA_WIDTH      = 64,
   parameter int AXIS_KEEP_WIDTH      = AXIS_DATA_WIDTH / 8,
   parameter int IP_ADDRESS_WIDTH     = 32,
   parameter int AXIS_KIP_TUSER_WIDTH = IP_ADDRESS_WIDTH
) (
   input  logic                                        i_clk,
   input  logic                                        i_ap_rst_n,
   input  logic [NUM_KERNELS-1:0]                      s_tvalid,
   output logic [NUM_KERNELS-1:0]                      s_tready,
   input  logic [NUM_KERNELS*AXIS_DATA_WIDTH-1:0]      s_tdata,
   input  logic [NUM_KERNELS*AXIS_KEEP_WIDTH-1:0]      s_tkeep,
   input  logic [NUM_KERNELS*AXIS_KIP_TUSER_WIDTH-1:0] s_tuser,
   input  logic [NUM_KERNELS-1:0]                      s_tlast,
   output logic                                        to_router_tvalid,
   input  logic                                        to_router_tready,
   output logic [AXIS_DATA_WIDTH-1:0]                  to_router_tdata,
   output logic [AXIS_KEEP_WIDTH-1:0]                  to_router_tkeep,
   output logic [AXIS_KIP_TUSER_WIDTH-1:0]             to_router_tuser,
   output logic                                        to_router_tlast,
   output logic [$clog2(NUM_KERNELS)-1:0]              o_grant,
   output logic                                        o_busy
);

   localparam int GW = $clog2(NUM_KERNELS);
   localparam int DW = AXIS_DATA_WIDTH;
   localparam int KW = AXIS_KEEP_WIDTH;
   localparam int UW = AXIS_KIP_TUSER_WIDTH;
   localparam int BW = 1 + UW + KW + DW;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   // Handshake: a beat moves on an edge where valid & ready are both high.
   // Input readiness depends only on registered skid occupancy, never on to_router_tready.
   state_t          r_state;
   state_t          w_state_nxt;
   logic [GW-1:0]   r_grant;
   logic [GW-1:0]   w_grant_nxt;
   logic [GW-1:0]   r_rr_ptr;
   logic [GW-1:0]   w_rr_ptr_nxt;
   logic [GW-1:0]   w_pick;
   logic [GW-1:0]   w_idx;
   logic            w_found;
   logic [BW-1:0]   w_beat_arr [NUM_KERNELS];
   logic [BW-1:0]   w_in_beat;
   logic            w_accept;
   logic            w_skid_not_full;

   logic [BW-1:0]   r_mem [2];
   logic            r_wr_ptr;
   logic            r_rd_ptr;
   logic [1:0]      r_count;
   logic            w_push;
   logic            w_pop;
   logic [BW-1:0]   w_out_beat;

   for (genvar k = 0; k < NUM_KERNELS; k++) begin : g_unpack
      assign w_beat_arr[k] = {s_tlast[k], s_tuser[k*UW +: UW], s_tkeep[k*KW +: KW], s_tdata[k*DW +: DW]};
   end

   assign w_in_beat = w_beat_arr[r_grant];

   // Search order starts at the round-robin pointer and wraps.
   always_comb begin
      w_pick  = '0;
      w_found = 1'b0;
      w_idx   = '0;
      for (int i = 0; i < NUM_KERNELS; i++) begin
         w_idx = GW'((int'(r_rr_ptr) + i) % NUM_KERNELS);
         if (!w_found && s_tvalid[w_idx]) begin
            w_found = 1'b1;
            w_pick  = w_idx;
         end
      end
   end

   assign w_skid_not_full = (r_count != 2'd2);
   assign w_accept        = (r_state == ST_LOCKED) && s_tvalid[r_grant] && w_skid_not_full;

   always_comb begin
      w_state_nxt  = r_state;
      w_grant_nxt  = r_grant;
      w_rr_ptr_nxt = r_rr_ptr;
      s_tready     = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_grant_nxt = w_pick;
               w_state_nxt = ST_LOCKED;
            end
         end
         ST_LOCKED: begin
            s_tready[r_grant] = w_skid_not_full;
            if (w_accept && w_in_beat[BW-1]) begin
               w_rr_ptr_nxt = (r_grant == GW'(NUM_KERNELS - 1)) ? '0 : r_grant + 1'b1;
               w_state_nxt  = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
      if (!i_ap_rst_n) begin
         r_state  <= ST_IDLE;
         r_grant  <= '0;
         r_rr_ptr <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_grant  <= w_grant_nxt;
         r_rr_ptr <= w_rr_ptr_nxt;
      end
   end

   // Two-entry skid FIFO: output always comes from a register.
   assign w_push = w_accept;
   assign w_pop  = (r_count != 2'd0) && to_router_tready;

   always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
      if (!i_ap_rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_beat;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign w_out_beat       = r_mem[r_rd_ptr];
   assign to_router_tvalid = (r_count != 2'd0);
   assign to_router_tdata  = w_out_beat[DW-1:0];
   assign to_router_tkeep  = w_out_beat[DW +: KW];
   assign to_router_tuser  = w_out_beat[DW+KW +: UW];
   assign to_router_tlast  = w_out_beat[BW-1];
   assign o_grant          = r_grant;
   assign o_busy           = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_kip_kernel_arbiter.sv
// Bench for kip_kernel_arbiter: per-kernel drivers, per-kernel expected queues
// checked by an output monitor, plus directed timing and grant-order checks.
module tb_kip_kernel_arbiter;

   localparam int NK = 4;
   localparam int DW = 64;
   localparam int KW = 8;
   localparam int UW = 32;
   localparam int GW = 2;
   localparam int BW = 1 + UW + KW + DW;

   typedef logic [BW-1:0] beat_t;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic [NK-1:0]    s_tvalid;
   logic [NK-1:0]    s_tready;
   logic [NK*DW-1:0] s_tdata;
   logic [NK*KW-1:0] s_tkeep;
   logic [NK*UW-1:0] s_tuser;
   logic [NK-1:0]    s_tlast;
   logic             to_router_tvalid;
   logic             to_router_tready;
   logic [DW-1:0]    to_router_tdata;
   logic [KW-1:0]    to_router_tkeep;
   logic [UW-1:0]    to_router_tuser;
   logic             to_router_tlast;
   logic [GW-1:0]    o_grant;
   logic             o_busy;

   beat_t drv_beat [NK];

   for (genvar g = 0; g < NK; g++) begin : g_pack
      assign s_tdata[g*DW +: DW] = drv_beat[g][DW-1:0];
      assign s_tkeep[g*KW +: KW] = drv_beat[g][DW +: KW];
      assign s_tuser[g*UW +: UW] = drv_beat[g][DW+KW +: UW];
      assign s_tlast[g]          = drv_beat[g][BW-1];
   end

   kip_kernel_arbiter #(
      .NUM_KERNELS(NK), .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW),
      .IP_ADDRESS_WIDTH(32), .AXIS_KIP_TUSER_WIDTH(UW)
   ) dut (
      .i_clk(clk), .i_ap_rst_n(rst_n),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
      .s_tkeep(s_tkeep), .s_tuser(s_tuser), .s_tlast(s_tlast),
      .to_router_tvalid(to_router_tvalid), .to_router_tready(to_router_tready),
      .to_router_tdata(to_router_tdata), .to_router_tkeep(to_router_tkeep),
      .to_router_tuser(to_router_tuser), .to_router_tlast(to_router_tlast),
      .o_grant(o_grant), .o_busy(o_busy)
   );

   // scoreboard state
   beat_t stim_q [NK][$];
   beat_t exp_q  [NK][$];
   int    got_order[$];
   int    pkt_seq [NK];
   int    checks = 0;
   int    failures = 0;
   int    in_cnt = 0;
   int    out_cnt = 0;
   int    valid_pct = 100;
   int    sink_mode = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   function automatic beat_t mk_beat(input int k, input int pkt, input int b, input logic last,
                                     input logic [31:0] ip);
      logic [DW-1:0] d;
      logic [KW-1:0] kp;
      d  = {4'(k), 12'(pkt), 16'(b), 32'($urandom)};
      kp = 8'($urandom);
      return {last, ip, kp, d};
   endfunction

   task automatic send_pkt(input int k, input int len, input logic [31:0] ip);
      beat_t bt;
      for (int b = 0; b < len; b++) begin
         bt = mk_beat(k, pkt_seq[k], b, (b == len - 1), ip);
         stim_q[k].push_back(bt);
         exp_q[k].push_back(bt);
      end
      pkt_seq[k]++;
   endtask

   function automatic int pending();
      int n;
      n = 0;
      for (int k = 0; k < NK; k++) n += stim_q[k].size() + exp_q[k].size();
      return n;
   endfunction

   task automatic wait_drain(input int limit, input string name);
      int n;
      n = 0;
      while (pending() != 0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      check({name, "_drain_timeout"}, (n >= limit), 1'b0);
      repeat (3) @(negedge clk);
   endtask

   // expected kernel order packed as hex digits, first grant in the low nibble
   task automatic check_order(input string name, input int len, input logic [31:0] code);
      check({name, "_order_len"}, got_order.size(), len);
      for (int i = 0; i < len && i < got_order.size(); i++)
         check({name, "_order"}, got_order[i], (code >> (4 * i)) & 32'hF);
      got_order.delete();
   endtask

   task automatic wait_stim_size(input int k, input int sz, input string name);
      int n;
      n = 0;
      while (stim_q[k].size() != sz && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({name, "_progress_timeout"}, (n >= 50), 1'b0);
   endtask

   // driver: valid is held with a stable beat until accepted
   initial begin
      logic [NK-1:0] acc;
      s_tvalid = '0;
      for (int k = 0; k < NK; k++) drv_beat[k] = '0;
      forever begin
         @(negedge clk);
         acc = s_tvalid & s_tready;
         @(posedge clk);
         #1;
         for (int k = 0; k < NK; k++) begin
            if (acc[k] && stim_q[k].size() > 0) void'(stim_q[k].pop_front());
            if (stim_q[k].size() > 0 &&
                ((s_tvalid[k] && !acc[k]) || $urandom_range(99) < valid_pct)) begin
               s_tvalid[k] = 1'b1;
               drv_beat[k] = stim_q[k][0];
            end else begin
               s_tvalid[k] = 1'b0;
            end
         end
      end
   end

   // sink: mode 0 always ready, mode 1 random, mode 2 left to the test
   initial begin
      to_router_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (sink_mode == 0) to_router_tready = 1'b1;
         else if (sink_mode == 1) to_router_tready = 1'($urandom_range(1));
      end
   end

   // monitor
   initial begin
      logic  prev_stall;
      beat_t prev_beat;
      beat_t cur;
      beat_t e;
      logic  in_pkt;
      int    kid;
      int    cur_kid;
      prev_stall = 1'b0;
      prev_beat  = '0;
      in_pkt     = 1'b0;
      cur_kid    = 0;
      forever begin
         @(negedge clk);
         cur = {to_router_tlast, to_router_tuser, to_router_tkeep, to_router_tdata};
         if (!rst_n) begin
            in_pkt     = 1'b0;
            prev_stall = 1'b0;
         end else begin
            if (s_tready != '0) check("tready_only_grant", {o_busy, s_tready}, {1'b1, 4'(1 << o_grant)});
            in_cnt += $countones(s_tvalid & s_tready);
            if (prev_stall) check("stall_hold", {to_router_tvalid, cur}, {1'b1, prev_beat});
            if (to_router_tvalid && to_router_tready) begin
               out_cnt++;
               kid = int'(to_router_tdata[63:60]);
               if (kid >= NK || exp_q[kid].size() == 0) begin
                  check("unexpected_beat", cur, '0);
                  if (cur == '0) begin
                     failures++;
                     $display("FAIL unexpected_beat actual=0 required=none t=%0t", $time);
                  end
               end else begin
                  e = exp_q[kid].pop_front();
                  check("beat", cur, e);
               end
               if (in_pkt) check("contiguous", kid, cur_kid);
               else got_order.push_back(kid);
               cur_kid = kid;
               in_pkt  = !to_router_tlast;
            end
            prev_stall = to_router_tvalid && !to_router_tready;
            prev_beat  = cur;
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   // directed sequence
   initial begin
      logic [1:0] exp_busy [6];
      logic       exp_ov   [6];
      logic [3:0] exp_rdy  [6];
      int         oc0;
      int         n;
      for (int k = 0; k < NK; k++) pkt_seq[k] = 0;
      #1 rst_n = 1'b0;
      #11;
      check("rst_tvalid", to_router_tvalid, 1'b0);
      check("rst_tready", s_tready, 4'b0);
      check("rst_grant", o_grant, 2'd0);
      check("rst_busy", o_busy, 1'b0);

      // all four kernels busy from reset: grant order 0,1,2,3,0,1,2,3
      for (int p = 0; p < 2; p++)
         for (int k = 0; k < NK; k++) send_pkt(k, 2, 32'hC0A8_0000 + 32'(k));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_drain(200, "allbusy");
      check_order("allbusy", 8, 32'h3210_3210);

      // single kernel 1, 3 beats: one IDLE cycle, latency 1 per beat
      exp_busy = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
      exp_ov   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      exp_rdy  = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0};
      @(negedge clk);
      send_pkt(1, 3, 32'h0A00_0001);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("single_busy", o_busy, exp_busy[i][0]);
         check("single_out_valid", to_router_tvalid, exp_ov[i]);
         check("single_tready", s_tready, exp_rdy[i]);
         if (i == 1) check("single_grant", o_grant, 2'd1);
      end
      wait_drain(100, "single");
      check_order("single", 1, 32'h1);

      // kernel 0 arrives mid-packet of kernel 2; kernel 3 idle -> 2 then 0
      @(negedge clk);
      send_pkt(2, 4, 32'h0A00_0102);
      wait_stim_size(2, 3, "mid_a");
      send_pkt(0, 2, 32'h0A00_0100);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!(o_busy && o_grant == 2'd2)) break;
         check("mid_a_k0_blocked", s_tready[0], 1'b0);
      end
      wait_drain(100, "mid_a");
      check_order("mid_a", 2, 32'h02);

      // same with kernel 3 also waiting -> 2, 3, 0
      @(negedge clk);
      send_pkt(2, 4, 32'h0A00_0202);
      wait_stim_size(2, 3, "mid_b");
      send_pkt(0, 2, 32'h0A00_0200);
      send_pkt(3, 1, 32'h0A00_0203);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!(o_busy && o_grant == 2'd2)) break;
         check("mid_b_k0_blocked", s_tready[0], 1'b0);
      end
      wait_drain(100, "mid_b");
      check_order("mid_b", 3, 32'h032);

      // backpressure for 5 cycles during a 6-beat packet
      sink_mode = 2;
      to_router_tready = 1'b1;
      @(negedge clk);
      oc0 = out_cnt;
      send_pkt(1, 6, 32'hAC10_0001);
      n = 0;
      while (out_cnt == oc0 && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("bp_start_timeout", (n >= 20), 1'b0);
      @(posedge clk);
      #1 to_router_tready = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      check("bp_tready_low", s_tready[1], 1'b0);
      check("bp_absorbed", in_cnt - out_cnt, 2);
      check("bp_out_valid", to_router_tvalid, 1'b1);
      @(posedge clk);
      #1 to_router_tready = 1'b1;
      sink_mode = 0;
      wait_drain(100, "bp");
      check_order("bp", 1, 32'h1);

      // asynchronous reset during beat 3 of a 5-beat packet
      @(negedge clk);
      send_pkt(0, 5, 32'h0A00_0300);
      wait_stim_size(0, 3, "rst");
      #2 rst_n = 1'b0;
      #1;
      check("arst_tvalid", to_router_tvalid, 1'b0);
      check("arst_tready", s_tready, 4'b0);
      check("arst_busy", o_busy, 1'b0);
      check("arst_grant", o_grant, 2'd0);
      repeat (2) @(posedge clk);
      #2;
      for (int k = 0; k < NK; k++) begin
         stim_q[k].delete();
         exp_q[k].delete();
      end
      got_order.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_pkt(3, 2, 32'h0A00_0403);
      send_pkt(1, 2, 32'h0A00_0401);
      wait_drain(100, "post_rst");
      check_order("post_rst", 2, 32'h31);

      // random valid/ready traffic with random destination IPs
      valid_pct = 60;
      sink_mode = 1;
      for (int p = 0; p < 400; p++)
         send_pkt($urandom_range(NK - 1), $urandom_range(4, 1), $urandom);
      wait_drain(20000, "random");
      got_order.delete();
      for (int k = 0; k < NK; k++) check("final_exp_empty", exp_q[k].size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
